irda_flag_seq_gen: RTL and testbench

Parametrised flag/preamble sequence generator for the IrDA transmit path.
- Serialises a PAT_W-bit pattern (default 8'h7E, the MIR STA/STO flag) one bit per bit-slot strobe.
- Repeats the pattern a runtime-programmable number of times (e.g. MIR double start flag, multi-flag idle fill).
- Supports back-to-back chaining of sequences without gaps.
- Sits between the transmit framer control FSM and the bit-stuffing/encoder mux.

---
 rtl/irda_flag_seq_gen_if.sv | 33 +++
 rtl/irda_flag_seq_gen.sv | 117 +++++++++++
 tb/tb_irda_flag_seq_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/irda_flag_seq_gen_if.sv
// irda_flag_seq_gen_if: framer <-> flag generator signal bundle (abort pins when IRDA_FLAG_GEN_ABORT_EN)
interface irda_flag_seq_gen_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
);
  logic             bit_en_i;
  logic             start_i;
  logic [CNT_W-1:0] rep_cnt_i;
  logic             pat_sel_i;
  logic [PAT_W-1:0] pattern_i;
  logic             seq_out;
  logic             busy_o;
  logic             last_bit_o;
  logic             done_o;
`ifdef IRDA_FLAG_GEN_ABORT_EN
  logic             abort_i;
  logic             aborted_o;
`endif
  modport master (
    output bit_en_i, start_i, rep_cnt_i, pat_sel_i, pattern_i,
    input  seq_out, busy_o, last_bit_o, done_o
`ifdef IRDA_FLAG_GEN_ABORT_EN
    , output abort_i, input aborted_o
`endif
  );
  modport slave (
    input  bit_en_i, start_i, rep_cnt_i, pat_sel_i, pattern_i,
    output seq_out, busy_o, last_bit_o, done_o
`ifdef IRDA_FLAG_GEN_ABORT_EN
    , input abort_i, output aborted_o
`endif
  );
endinterface

// File: rtl/irda_flag_seq_gen.sv
// irda_flag_seq_gen: serialises a repeated flag pattern one bit per bit slot, with back-to-back chaining.
// Optional abort_i/aborted_o pins are enabled by defining IRDA_FLAG_GEN_ABORT_EN.
module irda_flag_seq_gen #(
  parameter int               PAT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(8'h7E),
  parameter int               CNT_W       = 4,
  parameter bit               MSB_FIRST   = 1'b1,
  parameter bit               IDLE_LVL    = 1'b0
) (
  input logic                clk,
  input logic                wb_rst_n_i,
  irda_flag_seq_gen_if.slave s
);
  localparam int            IW   = $clog2(PAT_W);
  localparam logic [IW-1:0] LAST = IW'(PAT_W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d, pat_q, pat_d, sel;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic             out_q, out_d, busy_q, busy_d, done_q, done_d;
  logic             start_ok, load;
`ifdef IRDA_FLAG_GEN_ABORT_EN
  logic             abt_q, abt_d;
  assign s.aborted_o = abt_q;
`endif
  function automatic logic first_bit(input logic [PAT_W-1:0] x);
    return MSB_FIRST ? x[PAT_W-1] : x[0];
  endfunction
  function automatic logic [PAT_W-1:0] shift(input logic [PAT_W-1:0] x);
    return MSB_FIRST ? x << 1 : x >> 1;
  endfunction
  assign sel          = s.pat_sel_i ? s.pattern_i : DEF_PATTERN;
  assign start_ok     = s.start_i && (s.rep_cnt_i != '0);
  assign s.seq_out    = out_q;
  assign s.busy_o     = busy_q;
  assign s.done_o     = done_q;
  assign s.last_bit_o = busy_q && (idx_q == LAST) && (reps_q == CNT_W'(1));
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    reps_d  = reps_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
`ifdef IRDA_FLAG_GEN_ABORT_EN
    abt_d   = 1'b0;
`endif
    if (s.bit_en_i) begin
      if (state_q == IDLE) load = start_ok;
`ifdef IRDA_FLAG_GEN_ABORT_EN
      else if (s.abort_i) begin
        state_d = IDLE;
        out_d   = IDLE_LVL;
        busy_d  = 1'b0;
        abt_d   = 1'b1;
      end
`endif
      else if (idx_q != LAST) begin
        idx_d = idx_q + IW'(1);
        sr_d  = shift(sr_q);
        out_d = first_bit(sr_d);
      end else if (reps_q > CNT_W'(1)) begin
        reps_d = reps_q - CNT_W'(1);
        idx_d  = '0;
        sr_d   = pat_q;
        out_d  = first_bit(pat_q);
      end else begin
        done_d = 1'b1;
        load   = start_ok;
        state_d = IDLE;
        out_d   = IDLE_LVL;
        busy_d  = 1'b0;
      end
    end
    // acceptance (fresh or chained) overrides the idle return above
    if (load) begin
      state_d = SHIFT;
      sr_d    = sel;
      pat_d   = sel;
      idx_d   = '0;
      reps_d  = s.rep_cnt_i;
      out_d   = first_bit(sel);
      busy_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      reps_q  <= '0;
      out_q   <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef IRDA_FLAG_GEN_ABORT_EN
      abt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      reps_q  <= reps_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef IRDA_FLAG_GEN_ABORT_EN
      abt_q   <= abt_d;
`endif
    end
  end
endmodule

// File: tb/tb_irda_flag_seq_gen.sv
// tb_irda_flag_seq_gen: MSB-first and LSB-first instances checked every clock against a bit-queue model.
module tb_irda_flag_seq_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  irda_flag_seq_gen_if #(.PAT_W(8), .CNT_W(4)) i0 ();
  irda_flag_seq_gen_if #(.PAT_W(8), .CNT_W(4)) i1 ();
  assign i1.bit_en_i  = i0.bit_en_i;
  assign i1.start_i   = i0.start_i;
  assign i1.rep_cnt_i = i0.rep_cnt_i;
  assign i1.pat_sel_i = i0.pat_sel_i;
  assign i1.pattern_i = i0.pattern_i;
`ifdef IRDA_FLAG_GEN_ABORT_EN
  assign i1.abort_i   = i0.abort_i;
`endif
  irda_flag_seq_gen #(.MSB_FIRST(1'b1)) dut0 (.clk(clk), .wb_rst_n_i(rst_n), .s(i0.slave));
  irda_flag_seq_gen #(.MSB_FIRST(1'b0)) dut1 (.clk(clk), .wb_rst_n_i(rst_n), .s(i1.slave));
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  logic q0[$];
  logic q1[$];
  logic done_e = 1'b0;
`ifdef IRDA_FLAG_GEN_ABORT_EN
  logic ab_e = 1'b0;
`endif
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  // a sequence is just the list of bits it will put on the line, in order
  task automatic push(input logic [3:0] rc, input logic ps, input logic [7:0] pat);
    logic [7:0] p;
    p = ps ? pat : 8'h7E;
    for (int r = 0; r < int'(rc); r++)
      for (int i = 0; i < 8; i++) begin
        q0.push_back(p[7-i]);
        q1.push_back(p[i]);
      end
  endtask
  task automatic check_all();
    chk("seq_msb",  i0.seq_out,    q0.size() != 0 ? q0[0] : 1'b0);
    chk("seq_lsb",  i1.seq_out,    q1.size() != 0 ? q1[0] : 1'b0);
    chk("busy_msb", i0.busy_o,     q0.size() != 0);
    chk("busy_lsb", i1.busy_o,     q1.size() != 0);
    chk("last_msb", i0.last_bit_o, q0.size() == 1);
    chk("last_lsb", i1.last_bit_o, q1.size() == 1);
    chk("done_msb", i0.done_o,     done_e);
    chk("done_lsb", i1.done_o,     done_e);
`ifdef IRDA_FLAG_GEN_ABORT_EN
    chk("abrt_msb", i0.aborted_o,  ab_e);
    chk("abrt_lsb", i1.aborted_o,  ab_e);
`endif
  endtask
  task automatic step(input logic en, input logic st, input logic [3:0] rc,
                      input logic ps, input logic [7:0] pat);
    @(negedge clk);
    i0.bit_en_i  = en;
    i0.start_i   = st;
    i0.rep_cnt_i = rc;
    i0.pat_sel_i = ps;
    i0.pattern_i = pat;
    done_e = 1'b0;
`ifdef IRDA_FLAG_GEN_ABORT_EN
    ab_e = 1'b0;
`endif
    if (en) begin
`ifdef IRDA_FLAG_GEN_ABORT_EN
      if (i0.abort_i && q0.size() != 0) begin
        q0.delete();
        q1.delete();
        ab_e = 1'b1;
      end else
`endif
      if (q0.size() != 0) begin
        q0.delete(0);
        q1.delete(0);
        if (q0.size() == 0) begin
          done_e = 1'b1;
          if (st && rc != 0) push(rc, ps, pat);
        end
      end else if (st && rc != 0) push(rc, ps, pat);
    end
    @(posedge clk);
    #1;
    if (i0.done_o) done_cnt++;
    check_all();
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    i0.bit_en_i = 1'b0;
    i0.start_i  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    done_e = 1'b0;
`ifdef IRDA_FLAG_GEN_ABORT_EN
    ab_e = 1'b0;
`endif
    check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    i0.bit_en_i  = 1'b0;
    i0.start_i   = 1'b0;
    i0.rep_cnt_i = 4'd0;
    i0.pat_sel_i = 1'b0;
    i0.pattern_i = 8'h00;
`ifdef IRDA_FLAG_GEN_ABORT_EN
    i0.abort_i   = 1'b0;
`endif
    #12 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    // default flag, one repetition, one bit slot every fourth clock
    for (int k = 0; k < 40; k++) step(k % 4 == 0, k == 0, 4'd1, 1'b0, 8'h00);
    // runtime pattern, two repetitions
    step(1'b1, 1'b1, 4'd2, 1'b1, 8'hC1);
    repeat (18) step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
    // chaining: start held across the end of the first sequence
    done_cnt = 0;
    for (int k = 0; k < 20; k++) step(1'b1, k <= 8, 4'd1, 1'b0, 8'h00);
    chk_i("chain_dones", done_cnt, 2);
    // zero repeat count is ignored, then a long stall mid-sequence
    repeat (3) step(1'b1, 1'b1, 4'd0, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 4'd1, 1'b1, 8'hA5);
    repeat (3) step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
    repeat (20) step(1'b0, 1'($urandom_range(0, 1)), 4'd3, 1'b1, 8'h0F);
    repeat (8) step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
    // reset during the second repetition, then a fresh start
    done_cnt = 0;
    step(1'b1, 1'b1, 4'd2, 1'b1, 8'h3C);
    repeat (10) step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
    pulse_reset();
    chk_i("rst_no_done", done_cnt, 0);
    step(1'b1, 1'b1, 4'd1, 1'b1, 8'h96);
    repeat (10) step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
`ifdef IRDA_FLAG_GEN_ABORT_EN
    step(1'b1, 1'b1, 4'd1, 1'b0, 8'h00);
    repeat (4) step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
    i0.abort_i = 1'b1;
    step(1'b1, 1'b1, 4'd1, 1'b0, 8'h00);
    i0.abort_i = 1'b0;
    repeat (3) step(1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
`endif
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
`ifdef IRDA_FLAG_GEN_ABORT_EN
      i0.abort_i = ($urandom_range(0, 31) == 0);
`endif
      step(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 8'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
